// File: rtl/crypto_cmd_sequencer_89.sv
// ---------------------------------------------------------------------------
// crypto_cmd_sequencer_89
//
// Upstream command sequencer for cryptoprocessor_wrapper_89. Host commands
// (instruction word plus an operand pair) are buffered in a FIFO. They are
// issued to the wrapper at most one per cycle. An optional idle gap follows
// every multiply. Readouts capture the redundant result pair and return it to
// the host.
//
// Handshakes (strict valid/ready): a transfer happens on a rising clk edge
// where valid && ready. A source holds valid and its payload until that edge.
// cmd_ready does not depend on cmd_valid, and res_valid does not depend on
// res_ready.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   cmd_valid/ready   host command handshake (cmd_ready = FIFO not full)
//   cmd_word          {opcode[23:21], srcA[20:14], srcB[13:7], dst[6:0]}
//   cmd_d1, cmd_d2    operand pair (used by opcode 1 only)
//   res_valid/ready   result handshake; res_d1/res_d2 hold dout_1/dout_2
//   illegal           sticky: opcode 6 or 7 was popped
//   busy              FIFO non-empty or FSM not idle
//   perf_issued       issued-instruction counter (0 unless SEQ_PERFCNT_EN)
//   get_output, data_en, ins_in, command_in, din_1, din_2   wrapper controls
//   dout_1, dout_2    wrapper read data
//   dbg_state_o       current FSM state (IDLE=0, GAP=1, READ=2, RESP=3)
//
// Build option: define SEQ_PERFCNT_EN to build the saturating perf_issued
// counter. Without it, perf_issued is tied to 0.
// ---------------------------------------------------------------------------
module crypto_cmd_sequencer_89 #(
    parameter int W        = 89,
    parameter int DEPTH    = 8,
    parameter int MUL_GAP  = 0,
    parameter int READ_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [23:0]  cmd_word,
    input  logic [W-1:0] cmd_d1,
    input  logic [W-1:0] cmd_d2,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_d1,
    output logic [W-1:0] res_d2,
    output logic         illegal,
    output logic         busy,
    output logic [15:0]  perf_issued,
    output logic         get_output,
    output logic         data_en,
    output logic         ins_in,
    output logic [23:0]  command_in,
    output logic [W-1:0] din_1,
    output logic [W-1:0] din_2,
    input  logic [W-1:0] dout_1,
    input  logic [W-1:0] dout_2,
    output logic [1:0]   dbg_state_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int EW = 24 + 2 * W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GAP  = 2'd1;
    localparam logic [1:0] ST_READ = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // ---------------- command FIFO ----------------
    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, full, empty;
    logic [EW-1:0] head;
    logic [23:0]   head_word;
    logic [2:0]    head_op;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem_q[rd_ptr_q];
    assign head_word = head[EW-1 -: 24];
    assign head_op   = head_word[23:21];
    assign count_d   = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_word, cmd_d1, cmd_d2};
    end

    // ---------------- FSM and output registers ----------------
    logic [1:0]   state_q, state_d;
    logic [15:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0]  rd_cnt_q, rd_cnt_d;
    logic         ins_in_q, ins_in_d, data_en_q, data_en_d, get_output_q, get_output_d;
    logic [23:0]  command_in_q, command_in_d;
    logic [W-1:0] din_1_q, din_1_d, din_2_q, din_2_d;
    logic         res_valid_q, res_valid_d;
    logic [W-1:0] res_d1_q, res_d1_d, res_d2_q, res_d2_d;
    logic         illegal_q, illegal_d;
    logic         issue;

    // A pop can happen in IDLE, and also in the RESP cycle where the result
    // handshake completes, so the next instruction leaves without a bubble.
    assign pop = !empty && ((state_q == ST_IDLE) || (state_q == ST_RESP && res_ready));

    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        ins_in_d     = 1'b0;
        data_en_d    = 1'b0;
        get_output_d = 1'b0;
        command_in_d = '0;
        din_1_d      = '0;
        din_2_d      = '0;
        res_valid_d  = res_valid_q;
        res_d1_d     = res_d1_q;
        res_d2_d     = res_d2_q;
        illegal_d    = illegal_q;
        issue        = 1'b0;

        case (state_q)
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 16'd1;
                if (gap_cnt_q == 16'(MUL_GAP - 1)) state_d = ST_IDLE;
            end
            ST_READ: begin
                // rd_cnt_q counts the cycles get_output has been visible.
                if (rd_cnt_q == 16'(READ_LAT)) begin
                    res_d1_d    = dout_1;
                    res_d2_d    = dout_2;
                    res_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    get_output_d = 1'b1;
                    command_in_d = command_in_q;
                    rd_cnt_d     = rd_cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: ;
        endcase

        if (pop) begin
            case (head_op)
                3'd0: begin
                    get_output_d = 1'b1;
                    command_in_d = head_word;
                    rd_cnt_d     = 16'd1;
                    state_d      = ST_READ;
                    issue        = 1'b1;
                end
                3'd1: begin
                    ins_in_d     = 1'b1;
                    data_en_d    = 1'b1;
                    command_in_d = head_word;
                    din_1_d      = head[2*W-1 -: W];
                    din_2_d      = head[W-1:0];
                    issue        = 1'b1;
                end
                3'd2, 3'd3, 3'd4, 3'd5: begin
                    ins_in_d     = 1'b1;
                    command_in_d = head_word;
                    issue        = 1'b1;
                    if (head_op == 3'd5 && MUL_GAP > 0) begin
                        gap_cnt_d = '0;
                        state_d   = ST_GAP;
                    end
                end
                default: illegal_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= ST_IDLE;
            gap_cnt_q    <= '0;
            rd_cnt_q     <= '0;
            ins_in_q     <= 1'b0;
            data_en_q    <= 1'b0;
            get_output_q <= 1'b0;
            command_in_q <= '0;
            din_1_q      <= '0;
            din_2_q      <= '0;
            res_valid_q  <= 1'b0;
            res_d1_q     <= '0;
            res_d2_q     <= '0;
            illegal_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q      <= count_d;
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            ins_in_q     <= ins_in_d;
            data_en_q    <= data_en_d;
            get_output_q <= get_output_d;
            command_in_q <= command_in_d;
            din_1_q      <= din_1_d;
            din_2_q      <= din_2_d;
            res_valid_q  <= res_valid_d;
            res_d1_q     <= res_d1_d;
            res_d2_q     <= res_d2_d;
            illegal_q    <= illegal_d;
        end
    end

`ifdef SEQ_PERFCNT_EN
    logic [15:0] perf_q;
    always_ff @(posedge clk) begin
        if (rst)                            perf_q <= '0;
        else if (issue && perf_q != 16'hFFFF) perf_q <= perf_q + 16'd1;
    end
    assign perf_issued = perf_q;
`else
    assign perf_issued = 16'h0000;
`endif

    assign ins_in      = ins_in_q;
    assign data_en     = data_en_q;
    assign get_output  = get_output_q;
    assign command_in  = command_in_q;
    assign din_1       = din_1_q;
    assign din_2       = din_2_q;
    assign res_valid   = res_valid_q;
    assign res_d1      = res_d1_q;
    assign res_d2      = res_d2_q;
    assign illegal     = illegal_q;
    assign busy        = !empty || (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_crypto_cmd_sequencer_89.sv
module tb_crypto_cmd_sequencer_89;
  localparam int W = 89;
  localparam int DEPTH = 8;
  localparam int MUL_GAP = 3;
  localparam int READ_LAT = 2;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, res_valid, res_ready, illegal, busy;
  logic get_output, data_en, ins_in;
  logic [23:0] cmd_word, command_in;
  logic [W-1:0] cmd_d1, cmd_d2, res_d1, res_d2, din_1, din_2, dout_1, dout_2;
  logic [15:0] perf_issued;
  logic [1:0] dbg_state_o;

  always #5 clk = ~clk;

  crypto_cmd_sequencer_89 #(.W(W), .DEPTH(DEPTH), .MUL_GAP(MUL_GAP), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_word(cmd_word),
    .cmd_d1(cmd_d1), .cmd_d2(cmd_d2), .res_valid(res_valid), .res_ready(res_ready),
    .res_d1(res_d1), .res_d2(res_d2), .illegal(illegal), .busy(busy), .perf_issued(perf_issued),
    .get_output(get_output), .data_en(data_en), .ins_in(ins_in), .command_in(command_in),
    .din_1(din_1), .din_2(din_2), .dout_1(dout_1), .dout_2(dout_2), .dbg_state_o(dbg_state_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- wrapper model and issue monitor ----------------
  logic [W-1:0] mem1 [128];
  logic [W-1:0] mem2 [128];
  logic [23:0] issue_cmd[$];
  int issue_cyc[$];
  logic issue_de[$];
  int issued_total = 0;
  int res_rise_cyc = 0;
  logic go_prev = 1'b0;
  logic rv_prev = 1'b0;

  assign dout_1 = get_output ? mem1[command_in[20:14]] : '0;
  assign dout_2 = get_output ? mem2[command_in[20:14]] : '0;

  always @(negedge clk) begin
    if (rst) begin
      go_prev = 1'b0;
      rv_prev = 1'b0;
      issued_total = 0;
    end else begin
      if (ins_in || (get_output && !go_prev)) begin
        issue_cmd.push_back(command_in);
        issue_cyc.push_back(cyc);
        issue_de.push_back(data_en);
        issued_total++;
      end
      if (ins_in && data_en) begin
        mem1[command_in[6:0]] = din_1;
        mem2[command_in[6:0]] = din_2;
      end
      if (res_valid && !rv_prev) res_rise_cyc = cyc;
      go_prev = get_output;
      rv_prev = res_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    issue_cmd.delete();
    issue_cyc.delete();
    issue_de.delete();
  endtask

  task automatic idle_in();
    cmd_valid = 1'b0;
    cmd_word = '0;
    cmd_d1 = '0;
    cmd_d2 = '0;
  endtask

  task automatic push(input logic [23:0] w, input logic [W-1:0] a, input logic [W-1:0] b, output int c);
    for (int n = 0; n < 200 && !cmd_ready; n++) begin
      cmd_valid = 1'b0;
      tick();
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: cmd_ready=%0b required 1 for word %06h", cmd_ready, w);
    end
    cmd_valid = 1'b1;
    cmd_word = w;
    cmd_d1 = a;
    cmd_d2 = b;
    c = cyc;
    tick();
  endtask

  task automatic wait_issues(input int n);
    for (int i = 0; i < 100 && issue_cmd.size() < n; i++) tick();
  endtask

  task automatic wait_res_valid();
    for (int i = 0; i < 100 && !res_valid; i++) tick();
  endtask

  // ---------------- scenarios ----------------
  logic [23:0] exp_q[$];

  task automatic test_reset();
    rst = 1'b1;
    res_ready = 1'b0;
    idle_in();
    tick();
    tick();
    checks++; if (ins_in !== 1'b0) begin errors++; $display("FAIL reset_ins_in: got %0b want 0", ins_in); end
    checks++; if (data_en !== 1'b0) begin errors++; $display("FAIL reset_data_en: got %0b want 0", data_en); end
    checks++; if (get_output !== 1'b0) begin errors++; $display("FAIL reset_get_output: got %0b want 0", get_output); end
    checks++; if (command_in !== 24'h0) begin errors++; $display("FAIL reset_command_in: got %06h want 0", command_in); end
    checks++; if (din_1 !== '0 || din_2 !== '0) begin errors++; $display("FAIL reset_din: got %0h/%0h want 0/0", din_1, din_2); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0b want 0", res_valid); end
    checks++; if (res_d1 !== '0 || res_d2 !== '0) begin errors++; $display("FAIL reset_res_d: got %0h/%0h want 0/0", res_d1, res_d2); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %0b want 0", illegal); end
    checks++; if (perf_issued !== 16'h0) begin errors++; $display("FAIL reset_perf: got %0d want 0", perf_issued); end
    checks++; if (dbg_state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state_o); end
    rst = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
  endtask

  task automatic test_load_read();
    int k, k2;
    clear_log();
    res_ready = 1'b0;
    push(24'h200000, 89'h123, 89'h456, k);
    push(24'h000000, '0, '0, k2);
    idle_in();
    wait_res_valid();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL load_read_valid: got %0b want 1", res_valid); end
    checks++; if (issue_cmd.size() != 2) begin errors++; $display("FAIL load_read_count: got %0d want 2", issue_cmd.size()); end
    checks++; if (issue_cmd[0] !== 24'h200000 || issue_de[0] !== 1'b1) begin errors++; $display("FAIL load_issue: got %06h de=%0b want 200000 de=1", issue_cmd[0], issue_de[0]); end
    checks++; if (issue_cyc[0] != k + 2) begin errors++; $display("FAIL load_latency: got cycle %0d want %0d", issue_cyc[0], k + 2); end
    checks++; if (issue_cmd[1] !== 24'h000000 || issue_cyc[1] != k + 3) begin errors++; $display("FAIL read_issue: got %06h@%0d want 000000@%0d", issue_cmd[1], issue_cyc[1], k + 3); end
    checks++; if (res_rise_cyc != k + 3 + READ_LAT) begin errors++; $display("FAIL read_latency: got cycle %0d want %0d", res_rise_cyc, k + 3 + READ_LAT); end
    checks++; if (res_d1 !== 89'h123 || res_d2 !== 89'h456) begin errors++; $display("FAIL read_data: got %0h/%0h want 123/456", res_d1, res_d2); end
    checks++; if ((res_d1 + res_d2) !== 89'h579) begin errors++; $display("FAIL read_sum: got %0h want 579", res_d1 + res_d2); end
    res_ready = 1'b1;
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL res_handshake: got %0b want 0", res_valid); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] words [5];
    int k0, k;
    words[0] = 24'h200000; words[1] = 24'h200001; words[2] = 24'h400002;
    words[3] = 24'h600003; words[4] = 24'h80C084;
    clear_log();
    exp_q.delete();
    push(words[0], 89'h1A1, 89'h2B2, k0);
    exp_q.push_back(words[0]);
    push(words[1], 89'h3C3, 89'h4D4, k);
    exp_q.push_back(words[1]);
    for (int i = 2; i < 5; i++) begin
      push(words[i], '0, '0, k);
      exp_q.push_back(words[i]);
    end
    idle_in();
    wait_issues(5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (issue_cmd[i] !== exp_q[i] || issue_cyc[i] != k0 + 2 + i) begin
        errors++;
        $display("FAIL b2b_%0d: got %06h@%0d want %06h@%0d", i, issue_cmd[i], issue_cyc[i], exp_q[i], k0 + 2 + i);
      end
    end
    checks++; if (issue_de[1] !== 1'b1 || issue_de[2] !== 1'b0) begin errors++; $display("FAIL b2b_data_en: got %0b,%0b want 1,0", issue_de[1], issue_de[2]); end
  endtask

  task automatic test_mul_gap();
    int k, k2;
    clear_log();
    push(24'hA08085, '0, '0, k);
    push(24'h400002, '0, '0, k2);
    idle_in();
    wait_issues(2);
    checks++; if (issue_cmd[0] !== 24'hA08085 || issue_cyc[0] != k + 2) begin errors++; $display("FAIL mul_issue: got %06h@%0d want A08085@%0d", issue_cmd[0], issue_cyc[0], k + 2); end
    checks++; if (issue_cmd[1] !== 24'h400002 || issue_cyc[1] - issue_cyc[0] != MUL_GAP + 1) begin errors++; $display("FAIL mul_gap: got %06h spacing %0d want 400002 spacing %0d", issue_cmd[1], issue_cyc[1] - issue_cyc[0], MUL_GAP + 1); end
  endtask

  task automatic test_full_backpressure();
    int k;
    clear_log();
    exp_q.delete();
    res_ready = 1'b0;
    push(24'h000000, '0, '0, k);
    idle_in();
    wait_res_valid();
    checks++; if (res_valid !== 1'b1 || res_d1 !== 89'h1A1 || res_d2 !== 89'h2B2) begin errors++; $display("FAIL full_read: got v=%0b %0h/%0h want v=1 1a1/2b2", res_valid, res_d1, res_d2); end
    for (int i = 0; i < DEPTH; i++) begin
      push(24'h400000 + 24'(i), '0, '0, k);
      exp_q.push_back(24'h400000 + 24'(i));
    end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_cmd_ready: got %0b want 0", cmd_ready); end
    idle_in();
    tick();
    checks++; if (issue_cmd.size() != 1 || busy !== 1'b1) begin errors++; $display("FAIL full_held: got %0d issues busy=%0b want 1 busy=1", issue_cmd.size(), busy); end
    res_ready = 1'b1;
    for (int i = DEPTH; i < DEPTH + 2; i++) begin
      push(24'h400000 + 24'(i), '0, '0, k);
      exp_q.push_back(24'h400000 + 24'(i));
    end
    idle_in();
    wait_issues(DEPTH + 3);
    checks++; if (issue_cmd.size() != DEPTH + 3) begin errors++; $display("FAIL full_count: got %0d want %0d", issue_cmd.size(), DEPTH + 3); end
    for (int i = 0; i < DEPTH + 2; i++) begin
      checks++;
      if (issue_cmd[i + 1] !== exp_q[i]) begin errors++; $display("FAIL full_order_%0d: got %06h want %06h", i, issue_cmd[i + 1], exp_q[i]); end
    end
`ifdef SEQ_PERFCNT_EN
    checks++; if (perf_issued !== 16'(issued_total)) begin errors++; $display("FAIL perf_count: got %0d want %0d", perf_issued, issued_total); end
`else
    checks++; if (perf_issued !== 16'h0) begin errors++; $display("FAIL perf_count: got %0d want 0", perf_issued); end
`endif
  endtask

  task automatic test_illegal();
    int k, k2;
    clear_log();
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_pre: got %0b want 0", illegal); end
    push(24'hE00000, '0, '0, k);
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_early: got %0b want 0", illegal); end
    push(24'h200005, 89'h7, 89'h8, k2);
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_set: got %0b want 1", illegal); end
    idle_in();
    for (int i = 0; i < 10; i++) tick();
    checks++; if (issue_cmd.size() != 1 || issue_cmd[0] !== 24'h200005 || issue_cyc[0] != k + 3) begin errors++; $display("FAIL illegal_skip: got %0d issues first %06h@%0d want 1 issue 200005@%0d", issue_cmd.size(), issue_cmd[0], issue_cyc[0], k + 3); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %0b want 1", illegal); end
  endtask

  task automatic test_reset_mid_read();
    int k;
    clear_log();
    res_ready = 1'b0;
    push(24'h000000, '0, '0, k);
    idle_in();
    wait_res_valid();
    push(24'h004000, '0, '0, k);
    for (int i = 0; i < 3; i++) push(24'h400010 + 24'(i), '0, '0, k);
    idle_in();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (get_output !== 1'b1 || dbg_state_o !== 2'd2) begin errors++; $display("FAIL midread_state: got go=%0b st=%0d want go=1 st=2", get_output, dbg_state_o); end
    rst = 1'b1;
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL midread_res_valid: got %0b want 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midread_busy: got %0b want 0", busy); end
    checks++; if (get_output !== 1'b0 || command_in !== 24'h0) begin errors++; $display("FAIL midread_outputs: got go=%0b cmd=%06h want 0/0", get_output, command_in); end
    checks++; if (perf_issued !== 16'h0 || illegal !== 1'b0) begin errors++; $display("FAIL midread_clear: got perf=%0d illegal=%0b want 0/0", perf_issued, illegal); end
    rst = 1'b0;
    clear_log();
    for (int i = 0; i < 10; i++) tick();
    checks++; if (issue_cmd.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL midread_flush: got %0d issues busy=%0b want 0/0", issue_cmd.size(), busy); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem1[i] = '0;
      mem2[i] = '0;
    end
    rst = 1'b1;
    res_ready = 1'b0;
    idle_in();
    test_reset();
    test_load_read();
    test_back_to_back();
    test_mul_gap();
    test_full_backpressure();
    test_illegal();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
